// File: rtl/pled_color_sequencer_if.sv
// pled_color_sequencer_if: pins between the colour sequencer and the capture stage
// Signals: pll_lock (into sequencer), color[2:0] R/G/B drive, led composite, counter[2:0] colour index
interface pled_color_sequencer_if;
   logic       pll_lock;
   logic [2:0] color;
   logic       led;
   logic [2:0] counter;
   modport master (input pll_lock, output color, led, counter);
   modport slave  (output pll_lock, input color, led, counter);
endinterface

// File: rtl/pled_color_sequencer.sv
// pled_color_sequencer: PWM fade sequencer cycling the power LED through colour indices 1..7
// Ports: sys_clk PLL output clock; reset async active-low;
//        bus.pll_lock async lock input; bus.color R/G/B drive; bus.led any-channel-on; bus.counter colour index (0 = idle)
module pled_color_sequencer #(
   parameter int PWM_BITS     = 8,
   parameter int PRESCALE     = 39,
   parameter int STEP_PERIODS = 4,
   parameter int HOLD_PERIODS = 256,
   parameter int GAP_PERIODS  = 128
) (
   input  logic                   sys_clk,
   input  logic                   reset,
   pled_color_sequencer_if.master bus
);
   localparam int PRE_W     = (PRESCALE > 0) ? $clog2(PRESCALE + 1) : 1;
   localparam int STEP_W    = $clog2(STEP_PERIODS + 1);
   localparam int DWELL_MAX = (HOLD_PERIODS > GAP_PERIODS) ? HOLD_PERIODS : GAP_PERIODS;
   localparam int DWELL_W   = $clog2(DWELL_MAX + 1);
   localparam logic [PWM_BITS-1:0] DUTY_MAX = '1;
   typedef enum logic [2:0] {IDLE, FADE_UP, HOLD, FADE_DOWN, GAP} state_t;
   state_t              state, state_d;
   logic                sync1, lock_s;
   logic [PRE_W-1:0]    pre_cnt;
   logic [PWM_BITS-1:0] pwm_cnt, duty, duty_d;
   logic [STEP_W-1:0]   step_cnt, step_cnt_d;
   logic [DWELL_W-1:0]  dwell, dwell_d;
   logic [2:0]          counter, counter_d, color_q;
   logic                pwm_on, led_q, tick, period_end, step, halt;
   // Timebase is frozen while idle and flushed on the edge that drops to idle
   assign halt       = (state == IDLE) || !lock_s;
   assign tick       = (state != IDLE) && (pre_cnt == PRE_W'(PRESCALE));
   assign period_end = tick && (pwm_cnt == DUTY_MAX);
   assign step       = period_end && (step_cnt == STEP_W'(STEP_PERIODS - 1));
   assign bus.color   = color_q;
   assign bus.led     = led_q;
   assign bus.counter = counter;
   always_ff @(posedge sys_clk or negedge reset) begin
      if (!reset) begin
         sync1    <= 1'b0;
         lock_s   <= 1'b0;
         pre_cnt  <= '0;
         pwm_cnt  <= '0;
         pwm_on   <= 1'b0;
         color_q  <= '0;
         led_q    <= 1'b0;
         state    <= IDLE;
         duty     <= '0;
         counter  <= '0;
         step_cnt <= '0;
         dwell    <= '0;
      end else begin
         sync1    <= bus.pll_lock;
         lock_s   <= sync1;
         pre_cnt  <= (halt || tick) ? '0 : pre_cnt + 1'b1;
         pwm_cnt  <= halt ? '0 : (tick ? pwm_cnt + 1'b1 : pwm_cnt);
         pwm_on   <= pwm_cnt < duty;
         color_q  <= counter & {3{pwm_on}};
         led_q    <= pwm_on && (counter != 3'd0);
         state    <= state_d;
         duty     <= duty_d;
         counter  <= counter_d;
         step_cnt <= step_cnt_d;
         dwell    <= dwell_d;
      end
   end
   always_comb begin
      state_d    = state;
      duty_d     = duty;
      counter_d  = counter;
      step_cnt_d = period_end ? (step ? '0 : step_cnt + 1'b1) : step_cnt;
      dwell_d    = (period_end && (state == HOLD || state == GAP)) ? dwell + 1'b1 : dwell;
      case (state)
         IDLE: if (lock_s) begin
            state_d   = FADE_UP;
            counter_d = 3'd1;
         end
         FADE_UP: if (step) begin
            duty_d  = duty + 1'b1;
            state_d = (duty == DUTY_MAX - 1'b1) ? HOLD : FADE_UP;
         end
         HOLD: if (period_end && dwell == DWELL_W'(HOLD_PERIODS - 1)) state_d = FADE_DOWN;
         FADE_DOWN: if (step) begin
            duty_d  = duty - 1'b1;
            state_d = (duty == PWM_BITS'(1)) ? GAP : FADE_DOWN;
         end
         GAP: if (period_end && dwell == DWELL_W'(GAP_PERIODS - 1)) begin
            state_d   = FADE_UP;
            counter_d = (counter == 3'd7) ? 3'd1 : counter + 3'd1;
         end
         default: state_d = IDLE;
      endcase
      if (state_d != state) begin
         step_cnt_d = '0;
         dwell_d    = '0;
      end
      // Lock loss overrides any transition or duty step in the same cycle
      if (state != IDLE && !lock_s) begin
         state_d    = IDLE;
         duty_d     = '0;
         counter_d  = '0;
         step_cnt_d = '0;
         dwell_d    = '0;
      end
   end
endmodule
